// File: rtl/sram_responder.sv
// Target side of the SRAM access protocol: a flop-based word scratchpad that
// answers each accepted request after LATENCY cycles with a one-cycle ack.
module sram_responder #(
  parameter int ADDR_BITS  = 16,
  parameter int DEPTH_BITS = 6,
  parameter int DATA_BITS  = 32,
  parameter int LATENCY    = 3
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 req,
  input  logic                 read_enable,
  input  logic                 write_enable,
  input  logic [ADDR_BITS-1:0] address,
  input  logic [DATA_BITS-1:0] w_data,
  output logic [DATA_BITS-1:0] r_data,
  output logic                 ack,
  output logic                 busy,
  output logic                 err
);

  localparam int WORDS = 1 << DEPTH_BITS;
  localparam logic [3:0] COUNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t               state_reg, state_next;
  logic [3:0]           count_reg, count_next;
  logic [ADDR_BITS-1:0] addr_reg;
  logic [DATA_BITS-1:0] wdata_reg;
  logic                 rd_reg, wr_reg;
  logic [DATA_BITS-1:0] rdata_reg;
  logic [DATA_BITS-1:0] mem_reg [WORDS];
  logic [WORDS-1:0]     word_we;

  logic                  accept, enter_resp, commit;
  logic                  op_rd, op_wr, op_ok, range_ok;
  logic [ADDR_BITS-1:0]  op_addr;
  logic [DEPTH_BITS-1:0] index;

  // With LATENCY=1 the accept edge is also the edge entering RESP, so the
  // request fields must come straight from the inputs on that edge.
  assign accept   = (state_reg == IDLE) && req;
  assign op_rd    = accept ? read_enable  : rd_reg;
  assign op_wr    = accept ? write_enable : wr_reg;
  assign op_addr  = accept ? address      : addr_reg;
  assign op_ok    = op_rd ^ op_wr;
  assign range_ok = (op_addr >> DEPTH_BITS) == '0;
  assign index    = op_addr[DEPTH_BITS-1:0];

  assign enter_resp = (state_next == RESP) && (state_reg != RESP);
  assign commit     = (state_reg == RESP) && op_wr && !op_rd && range_ok;

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    ack        = 1'b0;
    busy       = 1'b0;
    err        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          if (LATENCY == 1) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            count_next = COUNT_LOAD;
          end
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (count_reg == 4'd0) begin
          state_next = RESP;
        end else begin
          count_next = count_reg - 4'd1;
        end
      end
      RESP: begin
        busy       = 1'b1;
        ack        = 1'b1;
        err        = !(op_ok && range_ok);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rd_reg    <= 1'b0;
      wr_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (accept) begin
        addr_reg  <= address;
        wdata_reg <= w_data;
        rd_reg    <= read_enable;
        wr_reg    <= write_enable;
      end
    end
  end

  // Out-of-range reads return zero rather than an aliased word.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rdata_reg <= '0;
    end else if (enter_resp && op_rd && !op_wr) begin
      rdata_reg <= range_ok ? mem_reg[index] : '0;
    end
  end

  assign r_data = rdata_reg;

  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word_we
      assign word_we[gi] = commit && (index == DEPTH_BITS'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < WORDS; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WORDS; i++) begin
        if (word_we[i]) begin
          mem_reg[i] <= wdata_reg;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: LATENCY=3 instance driven by a
// vector table, corner sequences and random traffic; plus a LATENCY=1 instance.
module tb_sram_responder;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        req = 1'b0, read_enable = 1'b0, write_enable = 1'b0;
  logic [15:0] address = '0;
  logic [31:0] w_data = '0;
  logic [31:0] r_data;
  logic        ack, busy, err;

  logic        req1 = 1'b0, re1 = 1'b0, we1 = 1'b0;
  logic [15:0] addr1 = '0;
  logic [31:0] wd1 = '0;
  logic [31:0] rdata1;
  logic        ack1, busy1, err1;

  sram_responder #(.ADDR_BITS(16), .DEPTH_BITS(6), .DATA_BITS(32), .LATENCY(LAT)) dut (
    .clk(clk), .n_rst(n_rst), .req(req), .read_enable(read_enable),
    .write_enable(write_enable), .address(address), .w_data(w_data),
    .r_data(r_data), .ack(ack), .busy(busy), .err(err)
  );

  sram_responder #(.ADDR_BITS(16), .DEPTH_BITS(6), .DATA_BITS(32), .LATENCY(1)) dut1 (
    .clk(clk), .n_rst(n_rst), .req(req1), .read_enable(re1),
    .write_enable(we1), .address(addr1), .w_data(wd1),
    .r_data(rdata1), .ack(ack1), .busy(busy1), .err(err1)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  string cur_tag = "init";

  logic [31:0] model_mem [64];
  logic [31:0] model_rdata;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h", cur_tag, name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) model_mem[i] = '0;
    model_rdata = '0;
  endtask

  // Transaction-level reference: legality, read result and write effect.
  task automatic model_apply(input logic rd, input logic wr, input logic [15:0] a,
                             input logic [31:0] d, output logic e, output logic [31:0] r);
    logic in_range;
    in_range = (a < 16'd64);
    e = !((rd ^ wr) && in_range);
    if (rd && !wr) model_rdata = in_range ? model_mem[int'(a)] : 32'd0;
    if (wr && !rd && in_range) model_mem[int'(a)] = d;
    r = model_rdata;
  endtask

  // Issues one request at the earliest legal cycle and checks every cycle
  // up to its ack; garbage is driven on the inputs while it is in flight.
  task automatic txn(input logic rd, input logic wr, input logic [15:0] a, input logic [31:0] d,
                     input logic exp_err, input logic [31:0] exp_rd);
    @(negedge clk);
    check("idle_busy", busy, 1'b0);
    check("idle_ack", ack, 1'b0);
    req = 1'b1; read_enable = rd; write_enable = wr; address = a; w_data = d;
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      check("busy", busy, 1'b1);
      check("ack", ack, c == LAT);
      check("err", err, (c == LAT) && exp_err);
      if (c == LAT) check("r_data", r_data, exp_rd);
      req          = (c < LAT) ? 1'($urandom) : 1'b0;
      read_enable  = 1'($urandom);
      write_enable = 1'($urandom);
      address      = 16'($urandom);
      w_data       = $urandom;
    end
    $display("txn %s rd=%0b wr=%0b addr=%h data=%h err=%0b r_data=%h",
             cur_tag, rd, wr, a, d, err, r_data);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        e;
    logic [31:0] r;
    int          n_acks;

    vecs[0]  = '{1'b1, 1'b0, 16'h0000, 32'h0,        1'b0, 32'h00000000};
    vecs[1]  = '{1'b0, 1'b1, 16'h0005, 32'hDEADBEEF, 1'b0, 32'h00000000};
    vecs[2]  = '{1'b1, 1'b0, 16'h0005, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[3]  = '{1'b0, 1'b1, 16'h0040, 32'h11111111, 1'b1, 32'hDEADBEEF};
    vecs[4]  = '{1'b1, 1'b0, 16'h0000, 32'h0,        1'b0, 32'h00000000};
    vecs[5]  = '{1'b1, 1'b1, 16'h0005, 32'h22222222, 1'b1, 32'h00000000};
    vecs[6]  = '{1'b0, 1'b0, 16'h0005, 32'h33333333, 1'b1, 32'h00000000};
    vecs[7]  = '{1'b1, 1'b0, 16'h0005, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[8]  = '{1'b1, 1'b0, 16'h8005, 32'h0,        1'b1, 32'h00000000};
    vecs[9]  = '{1'b0, 1'b1, 16'h003F, 32'hA5A5A5A5, 1'b0, 32'h00000000};
    vecs[10] = '{1'b1, 1'b0, 16'h003F, 32'h0,        1'b0, 32'hA5A5A5A5};
    vecs[11] = '{1'b1, 1'b0, 16'h0100, 32'h0,        1'b1, 32'h00000000};
    vecs[12] = '{1'b0, 1'b1, 16'h0045, 32'h00000001, 1'b1, 32'h00000000};
    vecs[13] = '{1'b1, 1'b0, 16'h0005, 32'h0,        1'b0, 32'hDEADBEEF};

    model_clear();
    cur_tag = "reset";
    repeat (2) @(negedge clk);
    check("r_data", r_data, 32'h0);
    check("ack", ack, 1'b0);
    check("busy", busy, 1'b0);
    check("err", err, 1'b0);
    check("r_data1", rdata1, 32'h0);
    check("busy1", busy1, 1'b0);
    n_rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      cur_tag = $sformatf("vec%0d", i);
      txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp_err, vecs[i].exp_rdata);
      model_apply(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, e, r);
    end

    // req held high for 8 cycles: only k and k+4 are accepted.
    cur_tag = "burst";
    n_acks = 0;
    for (int j = 0; j <= 8; j++) begin
      @(negedge clk);
      check("ack", ack, (j == 3) || (j == 7));
      check("busy", busy, j inside {1, 2, 3, 5, 6, 7});
      if (j == 3 || j == 7) check("r_data", r_data, model_mem[5]);
      if (ack) n_acks++;
      req = (j <= 7); read_enable = 1'b1; write_enable = 1'b0; address = 16'h0005;
    end
    check("ack_count", n_acks, 2);
    model_rdata = model_mem[5];
    $display("txn burst reads of addr 0005 acks=%0d r_data=%h", n_acks, r_data);

    // Reset during an in-flight write discards it and clears outputs at once.
    cur_tag = "rst_mid";
    @(negedge clk);
    check("busy_k", busy, 1'b0);
    req = 1'b1; read_enable = 1'b0; write_enable = 1'b1; address = 16'h0009; w_data = 32'h12345678;
    @(negedge clk);
    req = 1'b0;
    check("busy_k1", busy, 1'b1);
    @(negedge clk);
    check("busy_k2", busy, 1'b1);
    n_rst = 1'b0;
    #1;
    check("r_data_async", r_data, 32'h0);
    check("busy_async", busy, 1'b0);
    check("ack_async", ack, 1'b0);
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      check("ack_in_rst", ack, 1'b0);
      check("busy_in_rst", busy, 1'b0);
    end
    n_rst = 1'b1;
    model_clear();
    $display("txn rst_mid write of addr 0009 aborted by reset");
    cur_tag = "post_rst9";
    model_apply(1'b1, 1'b0, 16'h0009, 32'h0, e, r);
    txn(1'b1, 1'b0, 16'h0009, 32'h0, e, r);
    cur_tag = "post_rst5";
    model_apply(1'b1, 1'b0, 16'h0005, 32'h0, e, r);
    txn(1'b1, 1'b0, 16'h0005, 32'h0, e, r);

    for (int i = 0; i < 150; i++) begin
      logic        rd, wr;
      logic [15:0] a;
      logic [31:0] d;
      int          op;
      op = $urandom_range(0, 9);
      rd = (op <= 3) || (op == 8);
      wr = (op >= 4 && op <= 8);
      a  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : {10'd0, 6'($urandom)};
      d  = $urandom;
      cur_tag = $sformatf("rand%0d", i);
      model_apply(rd, wr, a, d, e, r);
      txn(rd, wr, a, d, e, r);
    end

    // LATENCY=1 instance: ack next cycle, req during RESP ignored.
    cur_tag = "lat1";
    @(negedge clk);
    check("busy_k", busy1, 1'b0);
    req1 = 1'b1; re1 = 1'b0; we1 = 1'b1; addr1 = 16'h0003; wd1 = 32'h00C0FFEE;
    @(negedge clk);
    check("ack_k1", ack1, 1'b1);
    check("busy_k1", busy1, 1'b1);
    check("err_k1", err1, 1'b0);
    check("rdata_k1", rdata1, 32'h0);
    req1 = 1'b1; re1 = 1'b1; we1 = 1'b0; addr1 = 16'h0007;
    @(negedge clk);
    check("busy_k2", busy1, 1'b0);
    check("ack_k2", ack1, 1'b0);
    req1 = 1'b1; re1 = 1'b1; we1 = 1'b0; addr1 = 16'h0003;
    @(negedge clk);
    check("ack_k3", ack1, 1'b1);
    check("busy_k3", busy1, 1'b1);
    check("err_k3", err1, 1'b0);
    check("rdata_k3", rdata1, 32'h00C0FFEE);
    req1 = 1'b0;
    $display("txn lat1 write/read addr 0003 r_data=%h", rdata1);
    @(negedge clk);
    check("busy_k4", busy1, 1'b0);
    check("ack_k4", ack1, 1'b0);
    req1 = 1'b1; re1 = 1'b1; we1 = 1'b1; addr1 = 16'h0003;
    @(negedge clk);
    check("ack_k5", ack1, 1'b1);
    check("err_k5", err1, 1'b1);
    check("rdata_k5", rdata1, 32'h00C0FFEE);
    req1 = 1'b0;
    @(negedge clk);
    check("busy_k6", busy1, 1'b0);
    check("err_k6", err1, 1'b0);
    $display("txn lat1 illegal both-enables err=%0b r_data=%h", err1, rdata1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Target (memory) side of the SRAM access protocol that the team's SRAM initiator block drives.
- Small flop-based word memory that answers requests with a fixed, parameterised latency and a one-cycle ack.
- Used as an on-chip scratchpad stand-in for the external SRAM, and as a synthesizable responder for block-level integration.
- With LATENCY=3, ack lands in the same cycle as the initiator's done cycle.

Parameters:
- ADDR_BITS, 16: address bus width.
- DEPTH_BITS, 6: log2 of word count (64 words); valid addresses are 0 .. 2^DEPTH_BITS-1.
- DATA_BITS, 32: word width (4 bytes).
- LATENCY, 3: cycles from req to ack; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- req  in  1  single-cycle request strobe; address, enables and w_data are valid in this cycle.
- read_enable  in  1  read request.
- write_enable  in  1  write request.
- address  in  ADDR_BITS  word address.
- w_data  in  DATA_BITS  write data.
- r_data  out  DATA_BITS  read data; held until the next completed read.
- ack  out  1  one-cycle completion pulse.
- busy  out  1  high while a request is outstanding.
- err  out  1  one-cycle pulse with ack when the request was illegal.

Behaviour:
- Reset (asynchronous, n_rst=0):
  - State goes to IDLE; counter cleared.
  - r_data=0, ack=0, busy=0, err=0.
  - All memory words cleared to 0.
  - Any in-flight request is discarded: a pending write is not committed and r_data is not updated.
- State machine:
  - IDLE: on req=1 at edge k, latch address, w_data, read_enable and write_enable. If LATENCY=1 go to RESP; otherwise go to WAIT and load counter with LATENCY-2.
  - WAIT: decrement counter each cycle; go to RESP when counter = 0.
  - RESP: for one cycle, ack=1; then go to IDLE.
- Timing with req high in cycle k:
  - busy high in cycles k+1 .. k+LATENCY.
  - ack high in cycle k+LATENCY only.
  - busy low from cycle k+LATENCY+1.
  - busy is registered (state != IDLE), never combinational from req.
- req handling outside IDLE: ignored, including req in the RESP cycle. No queueing, no error. A new request is accepted no earlier than cycle k+LATENCY+1, so back-to-back throughput is one request per LATENCY+1 cycles.
- Legal request: exactly one of read_enable/write_enable = 1, and latched address < 2^DEPTH_BITS.
  - Read: r_data is updated with mem[address] at the edge entering RESP, so it is valid in the ack cycle and held afterwards.
  - Write: mem[address] is written with the latched w_data at the edge leaving RESP. A read accepted afterwards returns the new value. r_data is unchanged.
- Illegal request: err=1 together with ack.
  - Case 1: both enables = 1 or neither = 1. Memory and r_data unchanged.
  - Case 2: legal op with out-of-range address (any nonzero bit at position DEPTH_BITS or above). A write is dropped; a read sets r_data=0.
- Latched values only: inputs changing after the req cycle do not affect the request in flight.
- Index arithmetic: memory index = address[DEPTH_BITS-1:0], used only after the range check passes. No wrap-around aliasing.
- The counter is 4 bits and never underflows: WAIT is left at 0.

Test Plan:
- Reset then read address 0 -> ack in cycle k+3, r_data=0x00000000, err=0; busy high exactly cycles k+1..k+3.
- Write 0xDEADBEEF to address 5, then read address 5 at the earliest accepted req -> second ack shows r_data=0xDEADBEEF; r_data unchanged (0) during the write's ack.
- req asserted every cycle for 8 cycles, read of address 5 -> only requests at k and k+4 accepted; exactly 2 ack pulses (k+3, k+7).
- Write to address 0x0040 (out of range for DEPTH_BITS=6) then read address 0 -> first ack has err=1 and address 0 is unaltered; read with read_enable=write_enable=1 -> ack with err=1, r_data unchanged.
- Write 0x12345678 to address 9, assert n_rst=0 in cycle k+2 -> outputs 0 immediately, no ack; after release, read address 9 returns 0.
- Rebuild with LATENCY=1: read request at cycle k -> ack at k+1, busy high only in k+1; next req accepted at k+2.
